hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter SAT_W, default 16, width of the saturating stall and flush event counters.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 inst_id  input  22  instruction held in the IF/ID register; fields: opcode[21:18], rd[17:12], rs[11:6], rt[5:0].
REQ-005 id_valid  input  1  inst_id holds a real instruction, not a bubble.
REQ-006 branch_taken  input  1  branch or jump resolved taken by the instruction currently in the MEM stage.
REQ-007 stall  output  1  hold the PC and the IF/ID register this cycle.
REQ-008 bubble  output  1  load a NOP into ID/EX this cycle instead of the decoded instruction.
REQ-009 flush  output  1  clear IF/ID and ID/EX this cycle.
REQ-010 stall_cnt  output  SAT_W  count of cycles with stall=1, saturating.
REQ-011 flush_cnt  output  SAT_W  count of cycles with flush=1, saturating.

Function
REQ-012 Writer opcodes (write rd): SVPC 1111, LD 1110, ADD 0100, INC 0101, NEG 0110, SUB 0111.
REQ-013 rs readers: LD, ST 0011, ADD, INC, NEG, SUB, J 1000, BRZ 1001, JM 1010, BRN 1011.
REQ-014 rt readers: ST, ADD, SUB; NOP 0000 and every undefined opcode read and write nothing.
REQ-015 Scoreboard of three entries (EX, MEM, WB), each {valid, rd}; every cycle EX->MEM->WB shifts, and WB is dropped.
REQ-016 New EX entry = {id_valid & writer(opcode) & !stall & !flush, rd}; otherwise valid=0.
REQ-017 No forwarding: RAW hazard = id_valid and a used source (rs or rt) equals rd of any valid scoreboard entry.
REQ-018 On a RAW hazard with flush=0: stall=1 and bubble=1, both combinational, in the same cycle.
REQ-019 Stall latency: 3 cycles when the producer is in EX, 2 in MEM, 1 in WB; the consumer issues in the cycle after the producer leaves WB.
REQ-020 branch_taken=1: flush=1 in the same cycle, stall=0, bubble=0, EX entry invalidated, and the ID instruction is not entered.
REQ-021 branch_taken has priority over RAW hazard when both occur in the same cycle.
REQ-022 MEM and WB entries are not affected by flush.
REQ-023 FSM states: RUN (no hazard), STALL (hazard pending), FLUSH (branch_taken this cycle); state is registered and exposed only for debug, and outputs derive from current inputs plus the scoreboard.
REQ-024 Transitions: RUN->STALL on hazard; STALL->RUN when hazard clears; any->FLUSH on branch_taken; FLUSH->RUN next cycle unless branch_taken repeats.
REQ-025 stall_cnt and flush_cnt increment by 1 per qualifying cycle and hold at 2^SAT_W-1, with no wrap.
REQ-026 id_valid=0 never causes a stall, whatever the inst_id contents.

Reset
REQ-027 Reset clears all scoreboard entries, sets state to RUN, and sets stall_cnt=0 and flush_cnt=0.
REQ-028 While rst=1: stall=0, bubble=0, flush=0, regardless of other inputs.
REQ-029 Reset asserted mid-stall aborts the stall; the first cycle after release evaluates against an empty scoreboard.

Structure
REQ-030 A shared package holds the opcode constants, the instruction field bit positions, and the state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2).
REQ-031 Sub-module inst_usage decodes an opcode into {writes_rd, reads_rs, reads_rt}, is purely combinational, and is instantiated once.

Verification
REQ-032 Scenario: ADD r3,r1,r2 then SUB r4,r3,r5 back-to-back -> stall=1 and bubble=1 for exactly 3 cycles, then SUB issues; stall_cnt=3.
REQ-033 Scenario: ADD r3, two independent instructions, then INC r6,r3 -> exactly 1 stall cycle.
REQ-034 Scenario: LD r7 in EX with branch_taken=1 and a dependent instruction in ID -> flush=1, stall=0, EX entry cleared, and no stall on the next cycle; flush_cnt=1.
REQ-035 Scenario: ST with rt=r9 while SVPC r9 is in MEM -> 2 stall cycles; a J with rt field=r9 -> 0 stall cycles.
REQ-036 Scenario: rst pulsed during the second stall cycle -> outputs drop to 0 asynchronously, and the counters and scoreboard clear.
REQ-037 Scenario: SAT_W=4 with 20 forced stall cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: opcodes, instruction field
// positions, scoreboard entry layout and FSM state encoding.
package hazard_ctrl_pkg;

  localparam int INST_W = 22;
  localparam int REG_W  = 6;

  localparam int OPC_HI = 21;
  localparam int OPC_LO = 18;
  localparam int RD_HI  = 17;
  localparam int RD_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 6;
  localparam int RT_HI  = 5;
  localparam int RT_LO  = 0;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  typedef struct packed {
    logic writes_rd;
    logic reads_rs;
    logic reads_rt;
  } usage_t;

endpackage

// File: rtl/hazard_ctrl_inst_usage.sv
// Opcode decoder: which register fields an instruction writes and reads.
module inst_usage
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output usage_t     usage
);

  always_comb begin
    usage = '0;
    case (opcode)
      OP_SVPC:        usage.writes_rd = 1'b1;
      OP_LD, OP_INC, OP_NEG: begin
        usage.writes_rd = 1'b1;
        usage.reads_rs  = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        usage.writes_rd = 1'b1;
        usage.reads_rs  = 1'b1;
        usage.reads_rt  = 1'b1;
      end
      OP_ST: begin
        usage.reads_rs = 1'b1;
        usage.reads_rt = 1'b1;
      end
      OP_J, OP_BRZ, OP_JM, OP_BRN: usage.reads_rs = 1'b1;
      OP_NOP:         usage = '0;
      default:        usage = '0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock controller for a forwarding-free pipeline: scoreboard-based RAW
// stall/bubble generation, taken-branch flush and saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int SAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst_id,
  input  logic              id_valid,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [SAT_W-1:0]  stall_cnt,
  output logic [SAT_W-1:0]  flush_cnt
);

  logic [3:0]       opcode;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  usage_t           usage;

  sb_entry_t sb_p0;
  sb_entry_t sb_p1;
  sb_entry_t sb_p2;
  sb_entry_t sb_new;

  logic   rs_busy;
  logic   rt_busy;
  logic   raw;
  state_t state_q;
  state_t state_d;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (&v) ? v : v + {{(SAT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid && (e.rd == r);
  endfunction

  assign opcode = inst_id[OPC_HI:OPC_LO];
  assign rd     = inst_id[RD_HI:RD_LO];
  assign rs     = inst_id[RS_HI:RS_LO];
  assign rt     = inst_id[RT_HI:RT_LO];

  inst_usage u_inst_usage (
    .opcode (opcode),
    .usage  (usage)
  );

  assign rs_busy = sb_hit(sb_p0, rs) | sb_hit(sb_p1, rs) | sb_hit(sb_p2, rs);
  assign rt_busy = sb_hit(sb_p0, rt) | sb_hit(sb_p1, rt) | sb_hit(sb_p2, rt);
  assign raw     = id_valid & ((usage.reads_rs & rs_busy) | (usage.reads_rt & rt_busy));

  // Reset forces all control outputs low without waiting for a clock edge.
  assign flush  = branch_taken & ~rst;
  assign stall  = raw & ~branch_taken & ~rst;
  assign bubble = stall;

  assign sb_new.valid = id_valid & usage.writes_rd & ~stall & ~flush;
  assign sb_new.rd    = rd;

  // Scoreboard: p0 = EX, p1 = MEM, p2 = WB. A taken branch squashes the
  // younger instruction in EX, so it never reaches MEM; the older MEM entry
  // still retires into WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_p0 <= '0;
      sb_p1 <= '0;
      sb_p2 <= '0;
    end else begin
      sb_p0 <= sb_new;
      sb_p1 <= flush ? '0 : sb_p0;
      sb_p2 <= sb_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall)  state_d = ST_STALL;
      ST_STALL: if (!stall) state_d = ST_RUN;
      ST_FLUSH: state_d = stall ? ST_STALL : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (branch_taken) state_d = ST_FLUSH;
  end

endmodule
